// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a power-of-two FIFO feeding a registered
// serializer with configurable data width, parity and stop bits.
module uart_tx_fifo #(
    parameter int CLK_FREQ  = 12000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   put,
    input  logic [DATA_BITS-1:0]   data,
    input  logic                   ovf_clr,
    output logic                   tx,
    output logic                   busy,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow
);

    localparam int DIV      = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int AW       = $clog2(DEPTH);
    localparam int PW       = AW + 1;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int CW       = $clog2(STOP_LEN) + 1;
    localparam int IW       = $clog2(DATA_BITS) + 1;

    localparam logic [CW-1:0] BIT_END  = CW'(DIV - 1);
    localparam logic [CW-1:0] STOP_END = CW'(STOP_LEN - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic          PAR_ODD  = (PARITY == 1);
    localparam logic          HAS_PAR  = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [PW-1:0]        wr;
    logic [PW-1:0]        rd;
    logic [DATA_BITS-1:0] head;
    logic                 head_par;
    logic                 can_write;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 tx_q;

    // Occupancy and flags derive only from the registered pointers.
    assign count     = wr - rd;
    assign empty     = (count == '0);
    assign full      = (count == DEPTH_P);
    assign can_write = put && !full;
    assign head      = mem[rd[AW-1:0]];
    assign head_par  = (^head) ^ PAR_ODD;
    assign tx        = tx_q;
    assign busy      = (state != S_IDLE);

    // Storage array; no reset, contents are qualified by the pointers.
    always_ff @(posedge clk) begin
        if (can_write) begin
            mem[wr[AW-1:0]] <= data;
        end
    end

    // Write pointer and sticky overflow (a dropping put beats ovf_clr).
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr       <= '0;
            overflow <= 1'b0;
        end else begin
            if (can_write) begin
                wr <= wr + PW'(1);
            end
            if (put && full) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // Serializer: owns the read pointer, pops at IDLE or on the final stop cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            rd      <= '0;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    cnt  <= '0;
                    idx  <= '0;
                    if (!empty) begin
                        shreg   <= head;
                        par_bit <= head_par;
                        rd      <= rd + PW'(1);
                        tx_q    <= 1'b0;
                        state   <= S_START;
                    end
                end
                S_START: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        tx_q  <= shreg[0];
                        shreg <= shreg >> 1;
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        if (idx == LAST_BIT) begin
                            idx <= '0;
                            if (HAS_PAR) begin
                                tx_q  <= par_bit;
                                state <= S_PAR;
                            end else begin
                                tx_q  <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            idx   <= idx + IW'(1);
                            tx_q  <= shreg[0];
                            shreg <= shreg >> 1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_PAR: begin
                    if (cnt == BIT_END) begin
                        cnt   <= '0;
                        tx_q  <= 1'b1;
                        state <= S_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt == STOP_END) begin
                        cnt <= '0;
                        if (!empty) begin
                            shreg   <= head;
                            par_bit <= head_par;
                            rd      <= rd + PW'(1);
                            tx_q    <= 1'b0;
                            state   <= S_START;
                        end else begin
                            tx_q  <= 1'b1;
                            state <= S_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    tx_q  <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances (8N1 depth 4, 7E2 depth 4,
// 8N1 depth 8) sharing clock and reset, with a line receiver per instance.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_pass = 0;

    logic       put0 = 1'b0, put1 = 1'b0, put2 = 1'b0;
    logic [7:0] data0 = '0, data2 = '0;
    logic [6:0] data1 = '0;
    logic       clr0 = 1'b0, clr1 = 1'b0, clr2 = 1'b0;
    logic       tx0, tx1, tx2, busy0, busy1, busy2;
    logic       empty0, empty1, empty2, full0, full1, full2;
    logic       ovf0, ovf1, ovf2;
    logic [2:0] count0, count1;
    logic [3:0] count2;

    typedef struct {
        int         sel;
        logic [8:0] data;
        logic       par;
        logic       frm_ok;
        int         start;
    } rx_rec_t;

    rx_rec_t rxq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .DEPTH(4),
                   .PARITY(0), .STOP_BITS(1)) u0 (
        .clk(clk), .resetn(resetn), .put(put0), .data(data0), .ovf_clr(clr0),
        .tx(tx0), .busy(busy0), .empty(empty0), .full(full0), .count(count0), .overflow(ovf0));

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(7), .DEPTH(4),
                   .PARITY(2), .STOP_BITS(2)) u1 (
        .clk(clk), .resetn(resetn), .put(put1), .data(data1), .ovf_clr(clr1),
        .tx(tx1), .busy(busy1), .empty(empty1), .full(full1), .count(count1), .overflow(ovf1));

    uart_tx_fifo #(.CLK_FREQ(1000000), .BAUD(100000), .DATA_BITS(8), .DEPTH(8),
                   .PARITY(0), .STOP_BITS(1)) u2 (
        .clk(clk), .resetn(resetn), .put(put2), .data(data2), .ovf_clr(clr2),
        .tx(tx2), .busy(busy2), .empty(empty2), .full(full2), .count(count2), .overflow(ovf2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic tx_of(input int sel);
        case (sel)
            0:       return tx0;
            1:       return tx1;
            default: return tx2;
        endcase
    endfunction

    function automatic int nrec(input int sel);
        int n;
        n = 0;
        foreach (rxq[i]) if (rxq[i].sel == sel) n++;
        return n;
    endfunction

    task automatic check_rec(input string tag, input int sel, input int k,
                             input logic [8:0] exp_data, input int exp_start, input int exp_par);
        int n;
        int idx;
        n = 0;
        idx = -1;
        foreach (rxq[i]) begin
            if (rxq[i].sel == sel) begin
                if (n == k) idx = i;
                n++;
            end
        end
        if (idx < 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_data"}, 32'(rxq[idx].data), 32'(exp_data));
            check({tag, "_framing"}, 32'(rxq[idx].frm_ok), 32'd1);
            if (exp_start >= 0) check({tag, "_start"}, rxq[idx].start, exp_start);
            if (exp_par >= 0) check({tag, "_parity"}, 32'(rxq[idx].par), exp_par);
        end
    endtask

    task automatic bit_wait(inout bit live);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!resetn) live = 1'b0;
        end
    endtask

    // Receiver model: detects a start bit, samples each bit at its centre.
    task automatic rx_run(input int sel, input int dbits, input bit has_par, input int stops);
        rx_rec_t r;
        bit      live;
        forever begin
            tick();
            if (resetn && tx_of(sel) == 1'b0) begin
                r.sel = sel; r.start = cyc; r.data = '0; r.par = 1'b0; r.frm_ok = 1'b1;
                live = 1'b1;
                for (int i = 0; i < 5; i++) begin
                    tick();
                    if (!resetn) live = 1'b0;
                end
                if (tx_of(sel) !== 1'b0) r.frm_ok = 1'b0;
                for (int b = 0; b < dbits; b++) begin
                    bit_wait(live);
                    r.data[b] = tx_of(sel);
                end
                if (has_par) begin
                    bit_wait(live);
                    r.par = tx_of(sel);
                end
                for (int s = 0; s < stops; s++) begin
                    bit_wait(live);
                    if (tx_of(sel) !== 1'b1) r.frm_ok = 1'b0;
                end
                if (live) rxq.push_back(r);
            end
        end
    endtask

    initial rx_run(0, 8, 1'b0, 1);
    initial rx_run(1, 7, 1'b1, 2);
    initial rx_run(2, 8, 1'b0, 1);

    initial begin
        int         c0;
        int         n;
        int         maxc;
        bit         sawovf;
        bit         hi;
        logic [7:0] v3 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A};
        int         ec3 [5] = '{1, 1, 2, 3, 4};
        logic [7:0] v5 [40];
        int         r2;

        // Reset state
        repeat (3) tick();
        resetn = 1'b1;
        tick();
        check("rst_tx", tx0, 1);
        check("rst_busy", busy0, 0);
        check("rst_empty", empty0, 1);
        check("rst_full", full0, 0);
        check("rst_count", count0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_count2", count2, 0);

        // 1: single 8N1 character
        put0 = 1'b1; data0 = 8'h55;
        tick();
        c0 = cyc;
        put0 = 1'b0;
        check("t1_empty_e0", empty0, 0);
        check("t1_count_e0", count0, 1);
        check("t1_tx_e0", tx0, 1);
        tick();
        check("t1_tx_e1", tx0, 0);
        check("t1_empty_e1", empty0, 1);
        check("t1_busy_e1", busy0, 1);
        n = 0;
        while (busy0 && n < 300) begin n++; tick(); end
        check("t1_busy_len", n, 100);
        repeat (5) tick();
        check_rec("t1_rec", 0, 0, 9'h055, c0 + 1, -1);

        // 2: 7 data bits, even parity, 2 stop bits
        put1 = 1'b1; data1 = 7'h41;
        tick();
        put1 = 1'b0;
        check("t2_tx_e0", tx1, 1);
        tick();
        check("t2_tx_e1", tx1, 0);
        n = 0;
        while (busy1 && n < 300) begin n++; tick(); end
        check("t2_busy_len", n, 110);
        repeat (5) tick();
        check_rec("t2_rec", 1, 0, 9'h041, -1, 0);

        // 3: fill depth-4 FIFO from idle, then overflow
        maxc = 0;
        for (int i = 0; i < 5; i++) begin
            put0 = 1'b1; data0 = v3[i];
            tick();
            if (i == 0) c0 = cyc;
            check($sformatf("t3_count_%0d", i), count0, ec3[i]);
        end
        check("t3_full", full0, 1);
        check("t3_no_ovf", ovf0, 0);
        data0 = 8'hEE;
        tick();
        check("t3_ovf_set", ovf0, 1);
        check("t3_count_drop", count0, 4);

        // 4: clear loses to a dropping put, then clears alone
        clr0 = 1'b1; data0 = 8'hDD;
        tick();
        check("t4_ovf_setwins", ovf0, 1);
        check("t4_count", count0, 4);
        put0 = 1'b0;
        tick();
        check("t4_ovf_clr", ovf0, 0);
        clr0 = 1'b0;
        n = 0;
        while ((busy0 || !empty0) && n < 1000) begin n++; tick(); end
        check("t3_drain", n < 1000, 1);
        repeat (20) tick();
        check("t3_nframes", nrec(0), 6);
        for (int j = 0; j < 5; j++)
            check_rec($sformatf("t3_f%0d", j), 0, j + 1, {1'b0, v3[j]}, c0 + 1 + 100 * j, -1);

        // 5: stream 40 bytes through the depth-8 FIFO with throttling
        for (int i = 0; i < 40; i++) v5[i] = 8'((i * 73 + 29) & 255);
        maxc = 0; sawovf = 1'b0; n = 0;
        for (int i = 0; i < 40 && n < 20000; ) begin
            if (count2 <= 4'd5) begin
                put2 = 1'b1; data2 = v5[i]; i++;
            end else begin
                put2 = 1'b0;
            end
            tick();
            n++;
            if (int'(count2) > maxc) maxc = int'(count2);
            if (ovf2) sawovf = 1'b1;
        end
        put2 = 1'b0;
        check("t5_fed", n < 20000, 1);
        n = 0;
        while ((busy2 || !empty2) && n < 6000) begin n++; tick(); end
        check("t5_drain", n < 6000, 1);
        repeat (20) tick();
        check("t5_maxcount", maxc, 6);
        check("t5_no_ovf", sawovf, 0);
        check("t5_nframes", nrec(2), 40);
        for (int j = 0; j < 40; j++)
            check_rec($sformatf("t5_f%0d", j), 2, j, {1'b0, v5[j]}, -1, -1);

        // 6: asynchronous reset during data bit 3 with 3 bytes queued
        for (int i = 0; i < 4; i++) begin
            put2 = 1'b1; data2 = (i == 0) ? 8'hF0 : 8'(8'hA1 + i);
            tick();
            if (i == 0) c0 = cyc;
        end
        put2 = 1'b0;
        n = 0;
        while (cyc < c0 + 1 + 45 && n < 200) begin n++; tick(); end
        check("t6_count_pre", count2, 3);
        check("t6_tx_bit3", tx2, 0);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_tx_async", tx2, 1);
        check("t6_busy_async", busy2, 0);
        check("t6_count_async", count2, 0);
        check("t6_empty_async", empty2, 1);
        repeat (3) tick();
        resetn = 1'b1;
        hi = 1'b1;
        r2 = nrec(2);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (tx2 !== 1'b1 || busy2 !== 1'b0) hi = 1'b0;
        end
        check("t6_line_idle", hi, 1);
        check("t6_empty", empty2, 1);
        check("t6_count", count2, 0);
        check("t6_no_frame", r2, 40);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter with a built-in serializer. It replaces the fixed 8N1, unchecked-ring-buffer transmitter with a parametrised block that has configurable data width, parity and stop bits, full/overflow detection, an occupancy count and asynchronous reset. Producer logic (text/game engine, debug dumpers) pushes characters with a single-cycle `put`. The block drains the FIFO onto `tx` back-to-back with no inter-frame gap.

## Interface
- `CLK_FREQ`, 12000000: clock frequency in Hz.
- `BAUD`, 115200: line rate. Bit period `DIV = (CLK_FREQ + BAUD/2) / BAUD` cycles, rounded integer. `DIV` must be ≥ 2.
- `DATA_BITS`, 8: character width, legal range 5–9.
- `DEPTH`, 16: FIFO entries. Must be a power of two, ≥ 2.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `clk` in 1: single clock domain.
- `resetn` in 1: asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronous to `clk`, handled externally.
- `put` in 1: write strobe, sampled on rising `clk`.
- `data` in `DATA_BITS`: character to write, sampled with `put`.
- `ovf_clr` in 1: clears the sticky `overflow` flag.
- `tx` out 1: serial line, idle high.
- `busy` out 1: serializer is mid-frame.
- `empty` out 1: FIFO holds 0 entries.
- `full` out 1: FIFO holds `DEPTH` entries.
- `count` out `$clog2(DEPTH)+1`: FIFO occupancy, 0..`DEPTH`.
- `overflow` out 1: sticky flag; a `put` was dropped.

## Operation
- **FIFO storage**
  - Read pointer `rd` and write pointer `wr`, each `$clog2(DEPTH)+1` bits; the extra MSB disambiguates full from empty.
  - `count = wr - rd`, modulo the pointer width.
  - `empty = (count == 0)`, `full = (count == DEPTH)`. All three are registered-state-derived; they are not affected combinationally by `put`.
- **Write**
  - `put && !full`: `mem[wr] <= data`, `wr` increments.
  - `put && full`: data is dropped, pointers are unchanged, and `overflow <= 1`.
  - The full check uses the pre-edge state. A pop in the same cycle does not rescue the write.
- **Overflow flag**
  - `ovf_clr` clears `overflow`.
  - If `ovf_clr` and a dropping `put` occur in the same cycle, set wins and `overflow` stays 1.
- **Simultaneous put and pop** (not full): both happen; `count` is unchanged.
- **Serializer FSM**: states IDLE, START, DATA, PAR, STOP. A bit counter times each bit over `DIV` cycles.
  - IDLE: `tx = 1`. If `!empty`, pop: `shreg <= mem[rd]`, `rd` increments, and the parity bit is computed from the popped word. Next state is START.
  - START: `tx = 0` for `DIV` cycles, then DATA.
  - DATA: `tx = shreg[0]`, LSB first. Shift once per `DIV` cycles. After `DATA_BITS` bits, go to PAR if `PARITY != 0`, otherwise STOP.
  - PAR: `tx` = XOR of the data bits for even parity, or its inverse for odd, for `DIV` cycles. Then STOP.
  - STOP: `tx = 1` for `STOP_BITS * DIV` cycles. On the last cycle, if `!empty`, pop and go directly to START (no idle gap). Otherwise go to IDLE.
- **Status outputs**
  - `busy = (state != IDLE)`.
  - `tx` is driven from a register, so it is glitch-free.
- **Frame length**: `DIV * (1 + DATA_BITS + (PARITY != 0) + STOP_BITS)` cycles.

## Timing
- **Reset values**: `tx = 1`, `busy = 0`, `empty = 1`, `full = 0`, `count = 0`, `overflow = 0`, state = IDLE, `rd = wr = 0`.
- **Reset mid-frame**: `tx` goes to 1 immediately (asynchronous) and the FIFO contents are discarded (pointers zeroed). There is no partial-frame completion.
- **Write to status**: `put` sampled at edge E0 → `count`, `empty` and `full` update after E0.
- **Start latency** (FIFO empty and IDLE at E0): the pop occurs at E1 and `tx` falls after E1, i.e. 2 edges after `put`.
- **Back-to-back frames**: consecutive frames are contiguous. The start bit of frame N+1 begins the cycle after the last stop-bit cycle of frame N.
- **Memory read**: synchronous read of `mem[rd]` at the pop edge. A word written at E0 may be popped at E1.
- **Wrap-around**: pointers wrap naturally at `2*DEPTH`. No special cycle is spent on wrap.

## Test plan
Bench parameters: `CLK_FREQ = 1000000`, `BAUD = 100000`, giving `DIV = 10`.

1. **Single character, 8N1**: reset, then `put 0x55` → `tx` falls 2 edges later. Line carries 0,1,0,1,0,1,0,1,0,1, each bit 10 cycles (100-cycle frame). `busy` is high for exactly 100 cycles. `empty` deasserts for 1 cycle only.
2. **Even parity, 7-bit**: `DATA_BITS = 7`, `PARITY = 2`, `STOP_BITS = 2`, `put 0x41` → bits are start 0, data 1000001, parity 0, then stop 1,1. Frame is 110 cycles.
3. **Fill and overflow**: `DEPTH = 4`; put 5 bytes on 5 consecutive cycles starting with the FSM idle.
   - The first byte pops at the cycle after it is written. Then 4 more fit: `count` peaks at 4 and `full = 1`. No `overflow`.
   - A 6th put while full → dropped and `overflow = 1`.
   - `tx` emits exactly 5 frames, with no gaps.
4. **Overflow clear priority**: while full, `ovf_clr = 1` and `put = 1` in the same cycle → `overflow` stays 1. `ovf_clr` alone on the next cycle → `overflow = 0`.
5. **Wrap-around**: stream 40 random bytes with `DEPTH = 8`, throttling `put` to keep `count ≤ 6` → the receiver model decodes all 40 bytes in order. `overflow` stays 0 and `count` never exceeds 8.
6. **Reset mid-frame**: assert `resetn = 0` during data bit 3 with 3 bytes queued → `tx = 1` with no clock edge. After release: `empty = 1`, `count = 0`, and no frame is emitted.
